// File: rtl/sysregs_pkg.sv
// rtl/sysregs_pkg.sv - shared constants, lock state encoding and offset helpers for sysregs_bank
package sysregs_pkg;

  localparam logic [7:0] LOCK_KEY1 = 8'h55;
  localparam logic [7:0] LOCK_KEY2 = 8'hAA;

  // Encoding is visible to software through LOCK reads
  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_KEY1     = 2'd1,
    ST_LOCKED   = 2'd2
  } lock_state_t;

  function automatic int STAT_OFS(input int nctl);
    return nctl;
  endfunction

  function automatic int EN_OFS(input int nctl);
    return nctl + 1;
  endfunction

  function automatic int LOCK_OFS(input int nctl);
    return nctl + 2;
  endfunction

  // First channel offset: first even offset after LOCK
  function automatic int CHB(input int nctl);
    return ((nctl + 4) / 2) * 2;
  endfunction

endpackage

// File: rtl/sysregs_bank_if.sv
// rtl/sysregs_bank_if.sv - slave bus bundle between address decoder and sysregs_bank
interface sysregs_bank_if #(
  parameter int AW = 5
);

  logic [AW-1:0] slv_addr_i;
  logic [7:0]    slv_datawr_i;
  logic          slv_datawr_valid;
  logic [7:0]    slv_datard_o;
  logic          slv_req_i;
  logic          slv_rwn_i;

  modport master (
    output slv_addr_i,
    output slv_datawr_i,
    output slv_datawr_valid,
    output slv_req_i,
    output slv_rwn_i,
    input  slv_datard_o
  );

  modport slave (
    input  slv_addr_i,
    input  slv_datawr_i,
    input  slv_datawr_valid,
    input  slv_req_i,
    input  slv_rwn_i,
    output slv_datard_o
  );

endinterface

// File: rtl/sysregs_lock_fsm.sv
// rtl/sysregs_lock_fsm.sv - two-key unlock state machine guarding the control bank
module sysregs_lock_fsm
  import sysregs_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        wr_lock,
  input  logic        wr_other,
  input  logic [7:0]  wdata,
  output lock_state_t state_o
);

  lock_state_t state_q;
  lock_state_t state_d;

  // State register, comes out of reset unlocked
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= ST_UNLOCKED;
    else         state_q <= state_d;
  end

  // Next state: any stray write between the two keys relocks the bank
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_UNLOCKED: begin
        if (wr_lock) state_d = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (wr_lock && wdata == LOCK_KEY1) state_d = ST_KEY1;
      end
      ST_KEY1: begin
        if (wr_lock)       state_d = (wdata == LOCK_KEY2) ? ST_UNLOCKED : ST_LOCKED;
        else if (wr_other) state_d = ST_LOCKED;
      end
      default: state_d = ST_LOCKED;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: rtl/sysregs_bank.sv
// rtl/sysregs_bank.sv - lockable control registers, IRQ status/enable and peripheral channel pass-through
module sysregs_bank
  import sysregs_pkg::*;
#(
  parameter int                AW        = 5,
  parameter int                NCTL      = 4,
  parameter int                NCH       = 2,
  parameter logic [8*NCTL-1:0] CTL_RESET = (8*NCTL)'(8'h7F)
) (
  input  logic              clk,
  input  logic              resetn,
  sysregs_bank_if.slave     slv,
  output logic [8*NCTL-1:0] ctl_o,
  input  logic [7:0]        irq_set_i,
  output logic              irq_o,
  output logic              locked_o,
  output logic [7:0]        ch_d_o,
  input  logic [8*NCH-1:0]  ch_d_i,
  output logic [NCH-1:0]    ch_wr_o,
  output logic [NCH-1:0]    ch_rd_o,
  output logic              ch_ad_o
);

  localparam int STAT_A = STAT_OFS(NCTL);
  localparam int EN_A   = EN_OFS(NCTL);
  localparam int LOCK_A = LOCK_OFS(NCTL);
  localparam int CHB_A  = CHB(NCTL);

  logic [AW-1:0] addr;
  logic [7:0]    wdata;
  logic          wstb;
  logic          rstb;

  logic [NCTL-1:0] hit_ctl;
  logic [NCH-1:0]  hit_ch;
  logic            hit_stat;
  logic            hit_en;
  logic            hit_lock;
  logic            mapped;

  logic [7:0]  ctl_q [NCTL];
  logic [7:0]  stat_q;
  logic [7:0]  en_q;
  logic [7:0]  rdata;
  lock_state_t lock_state;
  logic        locked;

  assign addr  = slv.slv_addr_i;
  assign wdata = slv.slv_datawr_i;

  // Strobes are held off during reset so peripherals never see a spurious access
  assign wstb = resetn & slv.slv_req_i & ~slv.slv_rwn_i & slv.slv_datawr_valid;
  assign rstb = resetn & slv.slv_req_i &  slv.slv_rwn_i & slv.slv_datawr_valid;

  assign hit_stat = (addr == AW'(STAT_A));
  assign hit_en   = (addr == AW'(EN_A));
  assign hit_lock = (addr == AW'(LOCK_A));
  assign mapped   = (|hit_ctl) | hit_stat | hit_en | hit_lock | (|hit_ch);

  assign locked   = (lock_state != ST_UNLOCKED);
  assign locked_o = locked;

  for (genvar i = 0; i < NCTL; i++) begin : g_ctl
    assign hit_ctl[i] = (addr == AW'(i));

    // Control register, writes silently dropped while the bank is locked
    always_ff @(posedge clk) begin
      if (!resetn)                             ctl_q[i] <= CTL_RESET[8*i +: 8];
      else if (wstb && hit_ctl[i] && !locked)  ctl_q[i] <= wdata;
    end

    assign ctl_o[8*i +: 8] = ctl_q[i];
  end

  // Sticky status with write-1-to-clear; a same-cycle set overrides the clear
  always_ff @(posedge clk) begin
    if (!resetn) stat_q <= 8'h00;
    else         stat_q <= (stat_q & ~((wstb && hit_stat) ? wdata : 8'h00)) | irq_set_i;
  end

  // Interrupt enable, deliberately outside the lock
  always_ff @(posedge clk) begin
    if (!resetn)              en_q <= 8'h00;
    else if (wstb && hit_en)  en_q <= wdata;
  end

  assign irq_o = |(stat_q & en_q);

  sysregs_lock_fsm u_lock (
    .clk      (clk),
    .resetn   (resetn),
    .wr_lock  (wstb & hit_lock),
    .wr_other (wstb & mapped & ~hit_lock),
    .wdata    (wdata),
    .state_o  (lock_state)
  );

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign hit_ch[c]  = ({addr[AW-1:1], 1'b0} == AW'(CHB_A + 2*c));
    assign ch_wr_o[c] = wstb & hit_ch[c];
    assign ch_rd_o[c] = rstb & hit_ch[c];
  end

  assign ch_d_o  = wdata;
  assign ch_ad_o = addr[0];

  // Read mux, zero-latency; unmapped offsets fall through to 8'h00
  always_comb begin
    rdata = 8'h00;
    for (int i = 0; i < NCTL; i++) begin
      if (hit_ctl[i]) rdata = ctl_q[i];
    end
    if (hit_stat) rdata = stat_q;
    if (hit_en)   rdata = en_q;
    if (hit_lock) rdata = {6'b0, lock_state};
    for (int c = 0; c < NCH; c++) begin
      if (hit_ch[c]) rdata = ch_d_i[8*c +: 8];
    end
  end

  assign slv.slv_datard_o = rdata;

endmodule

// File: tb/tb_sysregs_bank.sv
// tb/tb_sysregs_bank.sv - directed table-driven bench for sysregs_bank
module tb_sysregs_bank;

  logic        clk;
  logic        resetn;
  logic [31:0] ctl_o;
  logic [7:0]  irq_set_i;
  logic        irq_o;
  logic        locked_o;
  logic [7:0]  ch_d_o;
  logic [15:0] ch_d_i;
  logic [1:0]  ch_wr_o;
  logic [1:0]  ch_rd_o;
  logic        ch_ad_o;

  int n_cmp = 0;
  int n_bad = 0;

  sysregs_bank_if #(.AW(5)) bus ();

  sysregs_bank #(.AW(5), .NCTL(4), .NCH(2)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .slv       (bus),
    .ctl_o     (ctl_o),
    .irq_set_i (irq_set_i),
    .irq_o     (irq_o),
    .locked_o  (locked_o),
    .ch_d_o    (ch_d_o),
    .ch_d_i    (ch_d_i),
    .ch_wr_o   (ch_wr_o),
    .ch_rd_o   (ch_rd_o),
    .ch_ad_o   (ch_ad_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         wr;
    bit         rd;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic [7:0] irq_set;
    logic [7:0] exp_rd;
    logic       exp_irq;
    logic       exp_locked;
    logic [7:0] exp_ctl0;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(bit wr, bit rd, logic [4:0] a, logic [7:0] d, logic [7:0] s,
                               logic [7:0] erd, logic eirq, logic elk, logic [7:0] ectl);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = a; v.wdata = d; v.irq_set = s;
    v.exp_rd = erd; v.exp_irq = eirq; v.exp_locked = elk; v.exp_ctl0 = ectl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit wr, input bit rd, input logic [4:0] a, input logic [7:0] d,
                       input logic [7:0] s);
    @(negedge clk);
    bus.slv_addr_i       = a;
    bus.slv_datawr_i     = d;
    bus.slv_req_i        = wr | rd;
    bus.slv_rwn_i        = rd;
    bus.slv_datawr_valid = wr | rd;
    irq_set_i            = s;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 8'h00, 8'h00);
  endtask

  initial begin
    resetn    = 1'b0;
    ch_d_i    = 16'h0000;
    irq_set_i = 8'h00;
    repeat (3) idle();
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("rst_irq", irq_o, 1'b0);
    chk("rst_locked", locked_o, 1'b0);
    chk("rst_ch_stb", {ch_wr_o, ch_rd_o}, 4'b0);

    //            wr rd addr  wdata  set   exp_rd irq lk ctl0
    vecs.push_back(mkv(0, 1, 0, 8'h00, 8'h00, 8'h7F, 0, 0, 8'h7F));
    vecs.push_back(mkv(0, 1, 1, 8'h00, 8'h00, 8'h00, 0, 0, 8'h7F));
    vecs.push_back(mkv(0, 1, 3, 8'h00, 8'h00, 8'h00, 0, 0, 8'h7F));
    vecs.push_back(mkv(0, 1, 6, 8'h00, 8'h00, 8'h00, 0, 0, 8'h7F));
    vecs.push_back(mkv(1, 0, 6, 8'h00, 8'h00, 8'h00, 0, 1, 8'h7F));
    vecs.push_back(mkv(1, 0, 0, 8'h3F, 8'h00, 8'h00, 0, 1, 8'h7F));
    vecs.push_back(mkv(0, 1, 0, 8'h00, 8'h00, 8'h7F, 0, 1, 8'h7F));
    vecs.push_back(mkv(0, 1, 6, 8'h00, 8'h00, 8'h02, 0, 1, 8'h7F));
    vecs.push_back(mkv(1, 0, 6, 8'h55, 8'h00, 8'h00, 0, 1, 8'h7F));
    vecs.push_back(mkv(0, 1, 6, 8'h00, 8'h00, 8'h01, 0, 1, 8'h7F));
    vecs.push_back(mkv(1, 0, 6, 8'hAA, 8'h00, 8'h00, 0, 0, 8'h7F));
    vecs.push_back(mkv(0, 1, 6, 8'h00, 8'h00, 8'h00, 0, 0, 8'h7F));
    vecs.push_back(mkv(1, 0, 0, 8'h3F, 8'h00, 8'h00, 0, 0, 8'h3F));
    // broken key: relock, key1, stray EN write, key2
    vecs.push_back(mkv(1, 0, 6, 8'h00, 8'h00, 8'h00, 0, 1, 8'h3F));
    vecs.push_back(mkv(1, 0, 6, 8'h55, 8'h00, 8'h00, 0, 1, 8'h3F));
    vecs.push_back(mkv(1, 0, 5, 8'h01, 8'h00, 8'h00, 0, 1, 8'h3F));
    vecs.push_back(mkv(1, 0, 6, 8'hAA, 8'h00, 8'h00, 0, 1, 8'h3F));
    vecs.push_back(mkv(0, 1, 6, 8'h00, 8'h00, 8'h02, 0, 1, 8'h3F));
    vecs.push_back(mkv(0, 1, 5, 8'h00, 8'h00, 8'h01, 0, 1, 8'h3F));
    vecs.push_back(mkv(1, 0, 6, 8'h55, 8'h00, 8'h00, 0, 1, 8'h3F));
    vecs.push_back(mkv(1, 0, 6, 8'hAA, 8'h00, 8'h00, 0, 0, 8'h3F));
    // irq path
    vecs.push_back(mkv(1, 0, 5, 8'h05, 8'h00, 8'h00, 0, 0, 8'h3F));
    vecs.push_back(mkv(0, 0, 0, 8'h00, 8'h04, 8'h00, 1, 0, 8'h3F));
    vecs.push_back(mkv(0, 1, 4, 8'h00, 8'h00, 8'h04, 1, 0, 8'h3F));
    vecs.push_back(mkv(1, 0, 4, 8'h04, 8'h04, 8'h00, 1, 0, 8'h3F));
    vecs.push_back(mkv(0, 1, 4, 8'h00, 8'h00, 8'h04, 1, 0, 8'h3F));
    vecs.push_back(mkv(1, 0, 4, 8'h04, 8'h00, 8'h00, 0, 0, 8'h3F));
    vecs.push_back(mkv(0, 1, 4, 8'h00, 8'h00, 8'h00, 0, 0, 8'h3F));
    vecs.push_back(mkv(0, 0, 0, 8'h00, 8'h02, 8'h00, 0, 0, 8'h3F));
    vecs.push_back(mkv(0, 1, 4, 8'h00, 8'h00, 8'h02, 0, 0, 8'h3F));
    vecs.push_back(mkv(1, 0, 4, 8'h02, 8'h01, 8'h00, 1, 0, 8'h3F));
    vecs.push_back(mkv(0, 1, 4, 8'h00, 8'h00, 8'h01, 1, 0, 8'h3F));
    // unmapped offset and a few plain registers
    vecs.push_back(mkv(0, 1, 7, 8'h00, 8'h00, 8'h00, 1, 0, 8'h3F));
    vecs.push_back(mkv(1, 0, 7, 8'hFF, 8'h00, 8'h00, 1, 0, 8'h3F));
    vecs.push_back(mkv(0, 1, 4, 8'h00, 8'h00, 8'h01, 1, 0, 8'h3F));
    vecs.push_back(mkv(0, 1, 5, 8'h00, 8'h00, 8'h05, 1, 0, 8'h3F));
    vecs.push_back(mkv(0, 1, 1, 8'h00, 8'h00, 8'h00, 1, 0, 8'h3F));
    vecs.push_back(mkv(1, 0, 2, 8'hC3, 8'h00, 8'h00, 1, 0, 8'h3F));
    vecs.push_back(mkv(0, 1, 2, 8'h00, 8'h00, 8'hC3, 1, 0, 8'h3F));
    vecs.push_back(mkv(1, 0, 4, 8'hFF, 8'h00, 8'h00, 0, 0, 8'h3F));

    foreach (vecs[i]) begin
      drive(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].irq_set);
      if (vecs[i].rd) chk($sformatf("v%0d_rd", i), bus.slv_datard_o, vecs[i].exp_rd);
      chk($sformatf("v%0d_no_ch_stb", i), {ch_wr_o, ch_rd_o}, 4'b0);
      idle();
      chk($sformatf("v%0d_irq", i), irq_o, vecs[i].exp_irq);
      chk($sformatf("v%0d_locked", i), locked_o, vecs[i].exp_locked);
      chk($sformatf("v%0d_ctl0", i), ctl_o[7:0], vecs[i].exp_ctl0);
    end
    chk("ctl2_out", ctl_o[23:16], 8'hC3);

    // channel write at offset 11: one-cycle strobe on channel 1
    drive(1, 0, 5'd11, 8'hA1, 8'h00);
    chk("chw_wr", ch_wr_o, 2'b10);
    chk("chw_ad", ch_ad_o, 1'b1);
    chk("chw_d", ch_d_o, 8'hA1);
    chk("chw_rd", ch_rd_o, 2'b00);
    idle();
    chk("chw_wr_drop", ch_wr_o, 2'b00);

    // channel reads
    ch_d_i = 16'h775C;
    drive(0, 1, 5'd8, 8'h00, 8'h00);
    chk("chr0_data", bus.slv_datard_o, 8'h5C);
    chk("chr0_rd", ch_rd_o, 2'b01);
    chk("chr0_ad", ch_ad_o, 1'b0);
    drive(0, 1, 5'd10, 8'h00, 8'h00);
    chk("chr1_data", bus.slv_datard_o, 8'h77);
    chk("chr1_rd", ch_rd_o, 2'b10);
    idle();
    chk("chr_rd_drop", ch_rd_o, 2'b00);

    // unmapped write fires no strobe
    drive(1, 0, 5'd7, 8'h5A, 8'h00);
    chk("unm_stb", {ch_wr_o, ch_rd_o}, 4'b0);
    idle();

    // channel write between keys relocks, but the channel access itself goes through
    drive(1, 0, 5'd6, 8'h00, 8'h00);
    drive(1, 0, 5'd6, 8'h55, 8'h00);
    drive(0, 1, 5'd6, 8'h00, 8'h00);
    chk("k1_state", bus.slv_datard_o, 8'h01);
    drive(1, 0, 5'd9, 8'h12, 8'h00);
    chk("k1_chw", ch_wr_o, 2'b01);
    drive(1, 0, 5'd6, 8'hAA, 8'h00);
    drive(0, 1, 5'd6, 8'h00, 8'h00);
    chk("k1_relock", bus.slv_datard_o, 8'h02);
    idle();

    // held irq_set keeps the bit regardless of clears
    drive(1, 0, 5'd4, 8'h01, 8'h01);
    drive(1, 0, 5'd4, 8'h01, 8'h01);
    drive(0, 1, 5'd4, 8'h00, 8'h01);
    chk("held_stat", bus.slv_datard_o, 8'h01);
    chk("held_irq", irq_o, 1'b1);
    drive(1, 0, 5'd4, 8'h01, 8'h00);
    drive(0, 1, 5'd4, 8'h00, 8'h00);
    chk("held_clr", bus.slv_datard_o, 8'h00);
    chk("held_irq_off", irq_o, 1'b0);

    // reset in KEY1 with a pending interrupt
    drive(1, 0, 5'd6, 8'h55, 8'h00);
    drive(0, 0, 5'd0, 8'h00, 8'h04);
    idle();
    chk("pre_rst_irq", irq_o, 1'b1);
    chk("pre_rst_locked", locked_o, 1'b1);
    resetn = 1'b0;
    drive(1, 0, 5'd11, 8'hA1, 8'h00);
    chk("inrst_wr", ch_wr_o, 2'b00);
    drive(0, 1, 5'd8, 8'h00, 8'h00);
    chk("inrst_rd", ch_rd_o, 2'b00);
    @(negedge clk);
    resetn = 1'b1;
    idle();
    chk("post_rst_locked", locked_o, 1'b0);
    chk("post_rst_irq", irq_o, 1'b0);
    chk("post_rst_ctl", ctl_o, 32'h0000_007F);
    drive(0, 1, 5'd4, 8'h00, 8'h00);
    chk("post_rst_stat", bus.slv_datard_o, 8'h00);
    drive(0, 1, 5'd6, 8'h00, 8'h00);
    chk("post_rst_lock", bus.slv_datard_o, 8'h00);
    drive(0, 1, 5'd5, 8'h00, 8'h00);
    chk("post_rst_en", bus.slv_datard_o, 8'h00);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
